windowed_multichannel_accumulator: RTL

//   Parametrised N-channel signed accumulate-and-dump engine for streaming datapaths.

---
 rtl/accum_pkg.sv | 27 ++
 rtl/accum_sat_add.sv | 36 +++
 rtl/windowed_multichannel_accumulator.sv | 111 +++++++++++
 3 files changed

// File: rtl/accum_pkg.sv
// Shared helpers for the windowed multichannel accumulator: channel-index
// width, signed range limits and sign extension.
package accum_pkg;

  // Channel index width; a single-channel block still carries a 1-bit channel.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Largest signed value representable in w bits (w <= 64).
  function automatic longint sum_max(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  // Most negative signed value representable in w bits (w <= 64).
  function automatic longint sum_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

  // Sign-extend the low w bits of x to 64 bits.
  function automatic longint sext(input logic [63:0] x, input int w);
    logic [63:0] t;
    t = x << (64 - w);
    return $signed(t) >>> (64 - w);
  endfunction

endpackage

// File: rtl/accum_sat_add.sv
// Combinational signed accumulate step: sign-extends the sample, adds it to
// the running sum, flags two's-complement overflow and optionally clamps.
module accum_sat_add
  import accum_pkg::*;
#(
  parameter int IN_W     = 15,
  parameter int SUM_W    = 25,
  parameter bit SATURATE = 1'b1
) (
  input  logic [SUM_W-1:0] a,
  input  logic [IN_W-1:0]  b,
  output logic [SUM_W-1:0] y,
  output logic             ovf
);

  localparam logic [SUM_W-1:0] SUM_HI = SUM_W'(sum_max(SUM_W));
  localparam logic [SUM_W-1:0] SUM_LO = SUM_W'(sum_min(SUM_W));

  logic [SUM_W-1:0] b_ext;
  logic [SUM_W-1:0] raw;

  // Add, detect overflow from operand/result signs, then clamp if enabled.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    y     = '0;
    b_ext = SUM_W'(sext(64'(b), IN_W));
    raw   = a + b_ext;
    ovf   = (a[SUM_W-1] == b_ext[SUM_W-1]) && (raw[SUM_W-1] != a[SUM_W-1]);
    y     = raw;
    if (SATURATE && ovf) begin
      // Both operands share a sign on overflow, so a's sign picks the rail.
      y = a[SUM_W-1] ? SUM_LO : SUM_HI;
    end
  end

endmodule

// File: rtl/windowed_multichannel_accumulator.sv
// N-channel signed accumulate-and-dump engine. Each channel sums its tagged
// samples and emits the total after window_len samples, then restarts at 0.
module windowed_multichannel_accumulator
  import accum_pkg::*;
#(
  parameter int IN_W     = 15,
  parameter int SUM_W    = 25,
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 16,
  parameter bit SATURATE = 1'b1,
  localparam int CH_W    = clog2_min1(NUM_CH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [CH_W-1:0]  in_ch,
  input  logic [IN_W-1:0]  data_in,
  input  logic [CNT_W-1:0] window_len,
  output logic             out_valid,
  output logic [CH_W-1:0]  out_ch,
  output logic [SUM_W-1:0] out_sum,
  output logic             out_ovf
);

  logic [SUM_W-1:0] sum_q [NUM_CH];
  logic [CNT_W-1:0] cnt_q [NUM_CH];
  logic             ovf_q [NUM_CH];

  logic             ch_ok;
  logic [CH_W-1:0]  ch_idx;
  logic             accept;
  logic [SUM_W-1:0] nxt_sum;
  logic             add_ovf;
  logic [CNT_W:0]   cnt_inc;
  logic [CNT_W:0]   win_eff;
  logic             win_end;

  // Out-of-range channels are dropped; the index is forced to 0 so the
  // read mux never addresses a non-existent channel.
  assign ch_ok  = (32'(in_ch) < NUM_CH);
  assign ch_idx = ch_ok ? in_ch : '0;
  assign accept = in_valid && !clear && ch_ok;

  // One adder shared by all channels, fed through the channel read mux.
  accum_sat_add #(
    .IN_W    (IN_W),
    .SUM_W   (SUM_W),
    .SATURATE(SATURATE)
  ) u_add (
    .a  (sum_q[ch_idx]),
    .b  (data_in),
    .y  (nxt_sum),
    .ovf(add_ovf)
  );

  // Window end is a >= compare so shrinking window_len mid-window dumps on the
  // next sample; a window length of 0 behaves as 1.
  always_comb begin
    cnt_inc = {1'b0, cnt_q[ch_idx]} + (CNT_W + 1)'(1);
    win_eff = (window_len == '0) ? (CNT_W + 1)'(1) : {1'b0, window_len};
    win_end = (cnt_inc >= win_eff);
  end

  // Per-channel state: accumulate, or dump and restart, or clear everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: these per-channel arrays are flop banks, not RAM, so resetting them is legal and required.
      for (int i = 0; i < NUM_CH; i++) begin
        sum_q[i] <= '0;
        cnt_q[i] <= '0;
        ovf_q[i] <= 1'b0;
      end
    end else if (clear) begin
      for (int i = 0; i < NUM_CH; i++) begin
        sum_q[i] <= '0;
        cnt_q[i] <= '0;
        ovf_q[i] <= 1'b0;
      end
    end else if (accept) begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      if (win_end) begin
        sum_q[ch_idx] <= '0;
        cnt_q[ch_idx] <= '0;
        ovf_q[ch_idx] <= 1'b0;
      end else begin
        sum_q[ch_idx] <= nxt_sum;
        cnt_q[ch_idx] <= cnt_q[ch_idx] + CNT_W'(1);
        ovf_q[ch_idx] <= ovf_q[ch_idx] | add_ovf;
      end
    end
  end

  // Output registers: one-cycle valid pulse, payload held between dumps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
    end else begin
      out_valid <= accept && win_end;
      if (accept && win_end) begin
        out_ch  <= ch_idx;
        out_sum <= nxt_sum;
        out_ovf <= ovf_q[ch_idx] | add_ovf;
      end
    end
  end

endmodule
